// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4 - receive end of a 4-channel time-division serial link.
//
// Serial bits arrive one slot at a time in channel order a, b, c, d
// (slot index 0..3).  The block locks to a sync marker that flags
// channel a / frame 0.  It places each bit into its channel word at
// position bitcnt, so bit k of every word arrives in frame k (LSB first).
// When a full word period completes, it presents all four words at once.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bit_en     din/sync are meaningful this cycle; counters advance only then
//   din        serial TDM data bit
//   sync       word-start marker (qualified by bit_en)
//   ch_a..ch_d last completed word per channel, held until the next word
//   out_valid  one-cycle pulse when ch_a..ch_d update
//   locked     high while the FSM is in LOCKED (direct view of the state)
//   sync_err   one-cycle pulse on a misplaced or missing sync
//
// Handshake: there is no back-pressure.  A bit is consumed on every clock
// edge where bit_en is high, and out_valid is a single-cycle strobe that the
// consumer must take when it sees it.
// ---------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              din,
    input  logic              sync,
    output logic [DATA_W-1:0] ch_a,
    output logic [DATA_W-1:0] ch_b,
    output logic [DATA_W-1:0] ch_c,
    output logic [DATA_W-1:0] ch_d,
    output logic              out_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_nxt;
    logic [1:0]        slot_q, slot_nxt;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_nxt;
    logic [DATA_W-1:0] sr_q     [4];
    logic [DATA_W-1:0] sr_nxt   [4];
    logic [DATA_W-1:0] hold_nxt [4];
    logic              out_valid_nxt;
    logic              sync_err_nxt;

    logic              at_word_start;
    logic              at_word_end;
    logic              take_new;   // this bit starts a fresh word as channel a bit 0
    logic              take_bit;   // this bit is an ordinary data bit

    assign at_word_start = (slot_q == 2'd0) && (bitcnt_q == '0);
    assign at_word_end   = (slot_q == 2'd3) && (bitcnt_q == LAST_BIT);

    // The FSM has only two states, so locked is the state register itself.
    assign locked = (state_q == LOCKED);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state_q;
        slot_nxt      = slot_q;
        bitcnt_nxt    = bitcnt_q;
        out_valid_nxt = 1'b0;
        sync_err_nxt  = 1'b0;
        take_new      = 1'b0;
        take_bit      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sr_nxt[i] = sr_q[i];
        end
        hold_nxt[0] = ch_a;
        hold_nxt[1] = ch_b;
        hold_nxt[2] = ch_c;
        hold_nxt[3] = ch_d;

        case (state_q)
            HUNT: begin
                if (bit_en && sync) begin
                    take_new = 1'b1;
                end
            end
            LOCKED: begin
                if (bit_en) begin
                    if (at_word_start) begin
                        if (sync) begin
                            take_new = 1'b1;
                        end else begin
                            // Missing sync: drop the bit and re-acquire.
                            // slot/bitcnt are already 0 here.
                            sync_err_nxt = 1'b1;
                            state_nxt    = HUNT;
                        end
                    end else if (sync) begin
                        // Misplaced sync: trust the marker and restart on it.
                        sync_err_nxt = 1'b1;
                        take_new     = 1'b1;
                    end else begin
                        take_bit = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase

        if (take_new) begin
            // Clearing every channel discards any partial word.
            for (int i = 0; i < 4; i++) begin
                sr_nxt[i] = '0;
            end
            sr_nxt[0][0] = din;
            slot_nxt     = 2'd1;
            bitcnt_nxt   = '0;
            state_nxt    = LOCKED;
        end

        if (take_bit) begin
            sr_nxt[slot_q][bitcnt_q] = din;
            slot_nxt = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
                bitcnt_nxt = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + 1'b1;
            end
            if (at_word_end) begin
                // Load from sr_nxt so channel d's final bit is included.
                out_valid_nxt = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    hold_nxt[i] = sr_nxt[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            slot_q    <= 2'd0;
            bitcnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                sr_q[i] <= '0;
            end
            ch_a      <= '0;
            ch_b      <= '0;
            ch_c      <= '0;
            ch_d      <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            slot_q    <= slot_nxt;
            bitcnt_q  <= bitcnt_nxt;
            for (int i = 0; i < 4; i++) begin
                sr_q[i] <= sr_nxt[i];
            end
            ch_a      <= hold_nxt[0];
            ch_b      <= hold_nxt[1];
            ch_c      <= hold_nxt[2];
            ch_d      <= hold_nxt[3];
            out_valid <= out_valid_nxt;
            sync_err  <= sync_err_nxt;
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux4 - directed testbench for tdm_demux4 with DATA_W = 4.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.  Word bit k of channel s is sent as frame k, slot s.
// ---------------------------------------------------------------------------
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en;
    logic         din;
    logic         sync;
    logic [W-1:0] ch_a, ch_b, ch_c, ch_d;
    logic         out_valid;
    logic         locked;
    logic         sync_err;

    int checks  = 0;
    int errors  = 0;
    int ov_cnt  = 0;
    int se_cnt  = 0;
    int gap_bad = 0;

    // Expected held output words, maintained by the tests.
    logic [4*W-1:0] hold_exp;

    tdm_demux4 #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .din       (din),
        .sync      (sync),
        .ch_a      (ch_a),
        .ch_b      (ch_b),
        .ch_c      (ch_c),
        .ch_d      (ch_d),
        .out_valid (out_valid),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Pulse counters: each single-cycle pulse is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) ov_cnt++;
        if (sync_err === 1'b1) se_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic en, input logic d, input logic s);
        @(negedge clk);
        bit_en = en;
        din    = d;
        sync   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        bit_en = 1'b0;
        din    = 1'b0;
        sync   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends bits first..first+count-1 of a word period; sync on bit 0 only.
    // With max_gap > 0, random idle gaps of 1..max_gap cycles are inserted.
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d,
                             input int first, input int count, input int max_gap);
        logic [W-1:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = first; i < first + count; i++) begin
            int k;
            int s;
            k = i / 4;
            s = i % 4;
            if (max_gap > 0 && $urandom_range(0, 1) == 1) begin
                int g;
                g = $urandom_range(1, max_gap);
                for (int j = 0; j < g; j++) begin
                    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if (out_valid !== 1'b0 || sync_err !== 1'b0 ||
                        {ch_a, ch_b, ch_c, ch_d} !== hold_exp)
                        gap_bad++;
                end
            end
            step(1'b1, w[s][k], (i == 0));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_words: got %h expected 0000", {ch_a, ch_b, ch_c, ch_d});
        end
        checks++;
        if ({locked, out_valid, sync_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {locked, out_valid, sync_err});
        end
    endtask

    task automatic test_basic_word();
        int ov0, se0;
        ov0 = ov_cnt; se0 = se_cnt;
        hold_exp = 16'h0000;
        send_word(4'hA, 4'h5, 4'h3, 4'hC, 0, 16, 0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid: got %b expected 1", out_valid);
        end
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 16'hA53C) begin
            errors++;
            $display("FAIL basic_words: got %h expected a53c", {ch_a, ch_b, ch_c, ch_d});
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL basic_locked: got %b expected 1", locked);
        end
        hold_exp = 16'hA53C;
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || {ch_a, ch_b, ch_c, ch_d} !== hold_exp) begin
            errors++;
            $display("FAIL basic_hold: got valid=%b words=%h expected valid=0 words=%h",
                     out_valid, {ch_a, ch_b, ch_c, ch_d}, hold_exp);
        end
        checks++;
        if (ov_cnt - ov0 !== 1 || se_cnt - se0 !== 0) begin
            errors++;
            $display("FAIL basic_pulses: got ov=%0d se=%0d expected ov=1 se=0",
                     ov_cnt - ov0, se_cnt - se0);
        end
    endtask

    task automatic test_gaps();
        int ov0, se0;
        ov0 = ov_cnt; se0 = se_cnt; gap_bad = 0;
        send_word(4'hA, 4'h5, 4'h3, 4'hC, 0, 16, 3);
        checks++;
        if (out_valid !== 1'b1 || {ch_a, ch_b, ch_c, ch_d} !== 16'hA53C) begin
            errors++;
            $display("FAIL gaps_word: got valid=%b words=%h expected valid=1 words=a53c",
                     out_valid, {ch_a, ch_b, ch_c, ch_d});
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (gap_bad !== 0) begin
            errors++;
            $display("FAIL gaps_idle: got %0d disturbed gap cycles expected 0", gap_bad);
        end
        checks++;
        if (ov_cnt - ov0 !== 1 || se_cnt - se0 !== 0) begin
            errors++;
            $display("FAIL gaps_pulses: got ov=%0d se=%0d expected ov=1 se=0",
                     ov_cnt - ov0, se_cnt - se0);
        end
    endtask

    task automatic test_misplaced_sync();
        int ov0, se0;
        ov0 = ov_cnt; se0 = se_cnt;
        // Frame 0 complete plus frame 1 slots 0,1; next bit is frame 1 slot 2.
        send_word(4'hF, 4'hF, 4'hF, 4'hF, 0, 6, 0);
        step(1'b1, 1'b1, 1'b1);   // misplaced sync, carries a=1 bit 0
        checks++;
        if ({sync_err, out_valid, locked} !== 3'b101) begin
            errors++;
            $display("FAIL misplaced_flags: got err/valid/locked=%b expected 101",
                     {sync_err, out_valid, locked});
        end
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 16'hA53C) begin
            errors++;
            $display("FAIL misplaced_hold: got %h expected a53c", {ch_a, ch_b, ch_c, ch_d});
        end
        send_word(4'h1, 4'h2, 4'h4, 4'h8, 1, 15, 0);
        checks++;
        if (out_valid !== 1'b1 || {ch_a, ch_b, ch_c, ch_d} !== 16'h1248) begin
            errors++;
            $display("FAIL misplaced_word: got valid=%b words=%h expected valid=1 words=1248",
                     out_valid, {ch_a, ch_b, ch_c, ch_d});
        end
        hold_exp = 16'h1248;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (ov_cnt - ov0 !== 1 || se_cnt - se0 !== 1) begin
            errors++;
            $display("FAIL misplaced_pulses: got ov=%0d se=%0d expected ov=1 se=1",
                     ov_cnt - ov0, se_cnt - se0);
        end
    endtask

    task automatic test_missing_sync();
        int ov0, se0, bad;
        ov0 = ov_cnt; se0 = se_cnt; bad = 0;
        step(1'b1, 1'b1, 1'b0);   // word start without sync
        checks++;
        if ({sync_err, locked} !== 2'b10) begin
            errors++;
            $display("FAIL missing_flags: got err/locked=%b expected 10", {sync_err, locked});
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'(i), 1'b0);
            if (locked !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL missing_stay_hunt: got %0d locked cycles expected 0", bad);
        end
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 16'h1248 || ov_cnt - ov0 !== 0 || se_cnt - se0 !== 1) begin
            errors++;
            $display("FAIL missing_hold: got words=%h ov=%0d se=%0d expected words=1248 ov=0 se=1",
                     {ch_a, ch_b, ch_c, ch_d}, ov_cnt - ov0, se_cnt - se0);
        end
        send_word(4'h7, 4'hE, 4'h9, 4'h6, 0, 16, 0);
        checks++;
        if (out_valid !== 1'b1 || {ch_a, ch_b, ch_c, ch_d} !== 16'h7E96) begin
            errors++;
            $display("FAIL missing_relock: got valid=%b words=%h expected valid=1 words=7e96",
                     out_valid, {ch_a, ch_b, ch_c, ch_d});
        end
        hold_exp = 16'h7E96;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midword();
        send_word(4'h9, 4'h9, 4'h9, 4'h9, 0, 7, 0);
        @(negedge clk);
        rst = 1'b1; bit_en = 1'b1; din = 1'b1; sync = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 16'h0000 || {locked, out_valid, sync_err} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_clear: got words=%h flags=%b expected words=0000 flags=000",
                     {ch_a, ch_b, ch_c, ch_d}, {locked, out_valid, sync_err});
        end
        @(negedge clk);
        rst = 1'b0; bit_en = 1'b0;
        hold_exp = 16'h0000;
        send_word(4'h2, 4'hB, 4'hD, 4'h4, 0, 16, 0);
        checks++;
        if (out_valid !== 1'b1 || {ch_a, ch_b, ch_c, ch_d} !== 16'h2BD4) begin
            errors++;
            $display("FAIL midreset_word: got valid=%b words=%h expected valid=1 words=2bd4",
                     out_valid, {ch_a, ch_b, ch_c, ch_d});
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall_after_reset();
        int ov0, se0, bad;
        do_reset();
        ov0 = ov_cnt; se0 = se_cnt; bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'(i), 1'(~i));
            if (locked !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_locked: got %0d locked cycles expected 0", bad);
        end
        checks++;
        if (ov_cnt - ov0 !== 0 || se_cnt - se0 !== 0) begin
            errors++;
            $display("FAIL stall_pulses: got ov=%0d se=%0d expected ov=0 se=0",
                     ov_cnt - ov0, se_cnt - se0);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        din    = 1'b0;
        sync   = 1'b0;
        hold_exp = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic_word();
        test_gaps();
        test_misplaced_sync();
        test_missing_sync();
        test_reset_midword();
        test_stall_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the 4-channel time-division link whose transmit end is the 4:1 mux.
- Serial bits arrive one slot at a time in fixed channel order a, b, c, d. Slot index equals the mux select {s1,s0}: a=00, b=01, c=10, d=11.
- The block locks to a sync marker, tracks slot and bit position, and deserialises each channel into a DATA_W-bit word.
- It presents all four words together with a one-cycle valid pulse and flags framing errors.

Parameters:
- DATA_W, 8, bits per channel word; must be >= 2.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- bit_en, input, 1, din and sync are meaningful this cycle; all counters advance only when high.
- din, input, 1, serial TDM data bit.
- sync, input, 1, word-start marker, qualified by bit_en; marks slot 0 (channel a) of frame 0.
- ch_a, output, DATA_W, last completed word for channel a.
- ch_b, output, DATA_W, last completed word for channel b.
- ch_c, output, DATA_W, last completed word for channel c.
- ch_d, output, DATA_W, last completed word for channel d.
- out_valid, output, 1, one-cycle pulse when ch_a..ch_d update.
- locked, output, 1, high in LOCKED state.
- sync_err, output, 1, one-cycle pulse on a framing error.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=HUNT; slot=0; bitcnt=0; shift registers=0; ch_a..ch_d=0; out_valid=0; locked=0; sync_err=0. Reset overrides all other inputs in the same cycle. Reset mid-word discards the partial word, and the held outputs also return to 0.
- State HUNT:
  - bit_en&&sync: capture din as bit 0 of channel a; slot<=1; bitcnt<=0; go LOCKED.
  - Otherwise: din ignored, nothing changes.
- State LOCKED, on each bit_en cycle:
  - din shifts into the channel shift register selected by slot, LSB first. Bit index is bitcnt, so bit k of a word arrives in frame k.
  - slot increments modulo 4. When slot wraps 3->0, bitcnt increments modulo DATA_W.
- Word completion:
  - Trigger: bit_en with slot==3 and bitcnt==DATA_W-1.
  - On that edge, ch_a..ch_d load the complete words (channel d's final bit is included), and out_valid=1 for exactly that following cycle.
  - Latency: outputs are valid one clock after the last bit is presented.
  - Outputs hold until the next completion or reset.
- Framing checks, LOCKED, bit_en=1:
  - sync=1 with (slot!=0 or bitcnt!=0) is a misplaced sync. Action: sync_err pulses; partial word discarded; the current bit is taken as slot 0, bitcnt 0 of a new word (channel a bit 0); slot<=1; stay LOCKED; no out_valid.
  - sync=0 with slot==0 and bitcnt==0 is a missing sync. Action: sync_err pulses; go HUNT; the bit is discarded.
  - sync=1 at slot 0, bitcnt 0 is the expected case and is not an error.
- Simultaneous events:
  - A completion cannot coincide with a sync check, because they occur at different slots.
  - If a word completes, the next bit_en must carry sync.
- Stalls: with bit_en=0, no state changes, and out_valid and sync_err are 0.
- Ordering guarantee: ch_a..ch_d from one out_valid always belong to the same word period.

Test Plan:
1. DATA_W=4. Reset, then sync on the first bit, then 16 consecutive bit_en cycles carrying words a=A, b=5, c=3, d=C (bit k of each word in frame k). Required: out_valid pulses one cycle after the 16th bit; ch_a=A, ch_b=5, ch_c=3, ch_d=C; locked=1; sync_err never asserts.
2. Repeat scenario 1 with bit_en low on random cycles (gaps of 1-3 cycles). Required: identical words and a single out_valid. No output changes during gaps.
3. In LOCKED, assert sync at frame 1, slot 2. Required: sync_err pulses for one cycle, no out_valid. A full 16-bit word following that sync bit (a=1, b=2, c=4, d=8) produces exactly those values.
4. After a completed word, present the next bit with sync=0. Required: sync_err pulse, locked=0. The following bits are ignored until sync; outputs keep the previous word.
5. Assert rst mid-word (after 7 bits). Required: next cycle all outputs are 0, locked=0, out_valid=0. A subsequent clean word decodes correctly.
6. Hold bit_en=0 while toggling din and sync for 10 cycles after reset. Required: locked stays 0, no pulses on out_valid or sync_err.
